peripheral_bus_ctrl: RTL and testbench
======================================

# peripheral_bus_ctrl

Memory-mapped peripheral controller on the CPU data-memory bus of the single-cycle MIPS system. It decodes data-port accesses in the 0x4000_0000 window and owns the interval timer, LED, switch, 7-segment and system-tick registers. It generates the CPU interrupt request from the timer. Reads are combinational so the single-cycle core completes loads in one cycle; all register updates occur on the clock edge.

## Interface
- No parameters; the address map is fixed.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all registers immediately.
- `iMemAddr` in 32: byte address from the core's data port; bits [1:0] ignored.
- `iMemWrite` in 1: write strobe; sampled on the rising edge of `clk`.
- `iMemRead` in 1: read strobe; gates `oMemReadData`.
- `iMemWriteData` in 32: store data.
- `oMemReadData` out 32: combinational read data to the core's load mux.
- `iSwitch` in 8: board switches; unsynchronised inputs.
- `oLed` out 8: LED register.
- `oDigi` out 12: 7-segment drive register (anode/segment bits).
- `oInterrupt` out 1: timer interrupt request to the core `iInterrupt`.

## Operation
Address map, word-decoded on iMemAddr[31:2]:
- 0x4000_0000 TH: R/W, timer reload value.
- 0x4000_0004 TL: R/W, timer counter.
- 0x4000_0008 TCON: R/W bits [2:0]; reads bits [31:3] as 0.
  - bit0: enable.
  - bit1: interrupt enable.
  - bit2: interrupt status.
- 0x4000_000C LED: R/W bits [7:0].
- 0x4000_0010 SWITCH: read-only, returns {24'b0, switch_sync}.
- 0x4000_0014 DIGI: R/W bits [11:0].
- 0x4000_0018 SYSTICK: read-only, free-running 32-bit cycle counter.

Unmapped or read-only addresses:
- Reads return 0.
- Writes are ignored, with no side effects.

Read data:
- `oMemReadData` = selected register when `iMemRead`=1; 0 when `iMemRead`=0.
- A read has no side effect; reading TCON does not clear status.

Timer, evaluated each cycle with TCON[0]=1:
- If TL==32'hFFFF_FFFF: TL <= TH, and if TCON[1]=1 then TCON[2] <= 1.
- Otherwise TL <= TL+1.
- With TCON[0]=0, TL holds.

Interrupt and clear:
- `oInterrupt` = TCON[2], a registered output.
- Software clears the interrupt by writing TCON with bit2=0.
- Status is not cleared by disabling TCON[1].

Write priority:
- A CPU write to TL in the same cycle as increment or reload: the written value wins.
- A CPU write to TCON in the same cycle as an overflow setting status:
  - bits [1:0] take the written value;
  - bit2 = written bit2 OR overflow-set. The set wins, so no interrupt is lost.
- Overflow behaviour uses the pre-write TCON[0] and TCON[1].

Switches:
- `iSwitch` passes through a 2-flop synchroniser before being readable.

SYSTICK:
- Increments every cycle unconditionally.
- Wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values: TH=0, TL=0, TCON=0, LED=0, DIGI=0, SYSTICK=0, switch synchroniser=0.
- Outputs under reset: `oInterrupt`=0, `oLed`=0, `oDigi`=0.
- Reset asserted mid-count: the counter stops and clears asynchronously, and the interrupt drops in the same cycle.
- Write latency: a register written at edge N is visible on reads and outputs after edge N.
- Read latency: 0 cycles (combinational from `iMemAddr` and register state).
- Overflow-to-interrupt:
  - TL==FFFF_FFFF observed before edge N gives TCON[2]=1 and `oInterrupt`=1 after edge N.
  - The reload value TH is visible after the same edge.
- Reload period: TH=0xFFFF_FFFF-k gives one interrupt every k+1 enabled cycles.
- Switch read latency: 2 clock edges from an `iSwitch` change.
- No handshake or wait states: every access completes in the cycle it is presented.

## Test plan
- Reset, then read all 7 addresses:
  - TH/TL/TCON/LED/DIGI/SYSTICK read 0 with reset held;
  - `oInterrupt`=0, `oLed`=0, `oDigi`=0.
- Write TH=FFFF_FFFC, TL=FFFF_FFFC, then TCON=3:
  - `oInterrupt` rises exactly 4 cycles after the TCON write edge;
  - TL reads FFFF_FFFC after that edge;
  - the next interrupt period is 4 cycles after a status clear (write TCON=3).
- Overflow on the same edge as a TCON write of 3:
  - TCON reads 7 afterwards;
  - `oInterrupt` stays 1.
- Write TL=0x1234 on the same edge where the counter would increment: TL reads 0x1235 one cycle later.
- Write LED=0xA5 and DIGI=0xFFF: `oLed`=A5, `oDigi`=0xFFF.
- Set `iSwitch`=0x3C: SWITCH reads 0x3C two edges later.
- Read unmapped address 0x4000_001C: returns 0.
- SYSTICK:
  - two reads 10 cycles apart differ by 10;
  - with iMemRead=0, `oMemReadData`=0.

Source files
------------

// File: rtl/peripheral_bus_ctrl_if.sv
// Data-port bus between the single-cycle core and the peripheral controller,
// plus the board-facing pins the controller owns.
interface peripheral_bus_ctrl_if;
    logic [31:0] iMemAddr;
    logic        iMemWrite;
    logic        iMemRead;
    logic [31:0] iMemWriteData;
    logic [31:0] oMemReadData;
    logic [7:0]  iSwitch;
    logic [7:0]  oLed;
    logic [11:0] oDigi;
    logic        oInterrupt;

    // Core / board side: drives address, strobes, store data and switches.
    modport master (
        output iMemAddr,
        output iMemWrite,
        output iMemRead,
        output iMemWriteData,
        output iSwitch,
        input  oMemReadData,
        input  oLed,
        input  oDigi,
        input  oInterrupt
    );

    // Peripheral controller side.
    modport slave (
        input  iMemAddr,
        input  iMemWrite,
        input  iMemRead,
        input  iMemWriteData,
        input  iSwitch,
        output oMemReadData,
        output oLed,
        output oDigi,
        output oInterrupt
    );
endinterface

// File: rtl/peripheral_bus_ctrl.sv
// Memory-mapped peripheral block at 0x4000_0000: interval timer with
// interrupt, LEDs, switches, 7-segment drive and a free-running cycle counter.
// Loads are answered combinationally; all state changes on the rising edge.
module peripheral_bus_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    peripheral_bus_ctrl_if.slave  bus
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned LED_W   = 8;
    localparam int unsigned SW_W    = 8;
    localparam int unsigned DIGI_W  = 12;
    localparam int unsigned TCON_W  = 3;

    // Word addresses (byte address >> 2) of the register window.
    localparam logic [WADDR_W-1:0] ADDR_TH      = 30'h1000_0000;
    localparam logic [WADDR_W-1:0] ADDR_TL      = 30'h1000_0001;
    localparam logic [WADDR_W-1:0] ADDR_TCON    = 30'h1000_0002;
    localparam logic [WADDR_W-1:0] ADDR_LED     = 30'h1000_0003;
    localparam logic [WADDR_W-1:0] ADDR_SWITCH  = 30'h1000_0004;
    localparam logic [WADDR_W-1:0] ADDR_DIGI    = 30'h1000_0005;
    localparam logic [WADDR_W-1:0] ADDR_SYSTICK = 30'h1000_0006;

    // TCON bit positions.
    localparam int unsigned TCON_EN  = 0;
    localparam int unsigned TCON_IE  = 1;
    localparam int unsigned TCON_IRQ = 2;

    logic [WADDR_W-1:0] word_addr;
    logic [DATA_W-1:0]  wdata;

    logic [DATA_W-1:0]  th_q;
    logic [DATA_W-1:0]  tl_q;
    logic [TCON_W-1:0]  tcon_q;
    logic [LED_W-1:0]   led_q;
    logic [DIGI_W-1:0]  digi_q;
    logic [DATA_W-1:0]  systick_q;
    logic [SW_W-1:0]    sw_meta_q;
    logic [SW_W-1:0]    sw_sync_q;

    logic               wr_th;
    logic               wr_tl;
    logic               wr_tcon;
    logic               wr_led;
    logic               wr_digi;

    logic               overflow;
    logic               set_status;
    logic [DATA_W-1:0]  tl_d;
    logic [TCON_W-1:0]  tcon_d;
    logic [DATA_W-1:0]  rd_data;

    // Byte-offset bits carry no information for word registers.
    logic               unused_addr_bits;

    assign word_addr        = bus.iMemAddr[31:2];
    assign wdata            = bus.iMemWriteData;
    assign unused_addr_bits = ^bus.iMemAddr[1:0];

    // Write decode: only writable registers get a strobe, so stores to
    // SWITCH, SYSTICK or unmapped words fall through with no effect.
    always_comb begin
        wr_th   = 1'b0;
        wr_tl   = 1'b0;
        wr_tcon = 1'b0;
        wr_led  = 1'b0;
        wr_digi = 1'b0;
        if (bus.iMemWrite) begin
            case (word_addr)
                ADDR_TH:   wr_th   = 1'b1;
                ADDR_TL:   wr_tl   = 1'b1;
                ADDR_TCON: wr_tcon = 1'b1;
                ADDR_LED:  wr_led  = 1'b1;
                ADDR_DIGI: wr_digi = 1'b1;
                default:   ;
            endcase
        end
    end

    // Timer next state: overflow is judged on pre-write TCON, a CPU write to
    // TL beats count/reload, and a status set survives a concurrent TCON write.
    always_comb begin
        overflow   = tcon_q[TCON_EN] && (tl_q == {DATA_W{1'b1}});
        set_status = overflow && tcon_q[TCON_IE];

        tl_d = tl_q;
        if (wr_tl) begin
            tl_d = wdata;
        end else if (tcon_q[TCON_EN]) begin
            tl_d = overflow ? th_q : tl_q + DATA_W'(1);
        end

        tcon_d = tcon_q;
        tcon_d[TCON_IRQ] = tcon_q[TCON_IRQ] | set_status;
        if (wr_tcon) begin
            tcon_d = wdata[TCON_W-1:0];
            tcon_d[TCON_IRQ] = wdata[TCON_IRQ] | set_status;
        end
    end

    // Timer counter and control/status register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    // Plain software-written registers: reload value, LEDs, 7-segment drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            led_q  <= '0;
            digi_q <= '0;
        end else begin
            if (wr_th) begin
                th_q <= wdata;
            end
            if (wr_led) begin
                led_q <= wdata[LED_W-1:0];
            end
            if (wr_digi) begin
                digi_q <= wdata[DIGI_W-1:0];
            end
        end
    end

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= bus.iSwitch;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Free-running cycle counter; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_q + DATA_W'(1);
        end
    end

    // Combinational load path; unmapped words read as zero.
    always_comb begin
        rd_data = '0;
        case (word_addr)
            ADDR_TH:      rd_data = th_q;
            ADDR_TL:      rd_data = tl_q;
            ADDR_TCON:    rd_data = DATA_W'(tcon_q);
            ADDR_LED:     rd_data = DATA_W'(led_q);
            ADDR_SWITCH:  rd_data = DATA_W'(sw_sync_q);
            ADDR_DIGI:    rd_data = DATA_W'(digi_q);
            ADDR_SYSTICK: rd_data = systick_q;
            default:      rd_data = '0;
        endcase
    end

    assign bus.oMemReadData = bus.iMemRead ? rd_data : '0;
    assign bus.oLed         = led_q;
    assign bus.oDigi        = digi_q;
    assign bus.oInterrupt   = tcon_q[TCON_IRQ];

endmodule

// File: tb/tb_peripheral_bus_ctrl.sv
// Directed bench for peripheral_bus_ctrl: read expectations go through a
// scoreboard queue, outputs are checked with immediate assertions.
module tb_peripheral_bus_ctrl;

    localparam logic [31:0] A_TH      = 32'h4000_0000;
    localparam logic [31:0] A_TL      = 32'h4000_0004;
    localparam logic [31:0] A_TCON    = 32'h4000_0008;
    localparam logic [31:0] A_LED     = 32'h4000_000C;
    localparam logic [31:0] A_SWITCH  = 32'h4000_0010;
    localparam logic [31:0] A_DIGI    = 32'h4000_0014;
    localparam logic [31:0] A_SYSTICK = 32'h4000_0018;
    localparam logic [31:0] A_UNMAP   = 32'h4000_001C;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    // Reference cycle count since the last reset release.
    logic [31:0] ref_ticks;

    peripheral_bus_ctrl_if bus ();

    peripheral_bus_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side model of the free-running counter.
    always @(posedge clk or posedge reset) begin
        if (reset) ref_ticks <= '0;
        else       ref_ticks <= ref_ticks + 32'd1;
    end

    // Global time bound so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One store, taking effect at the next rising edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.iMemAddr      = addr;
        bus.iMemWriteData = data;
        bus.iMemWrite     = 1'b1;
        bus.iMemRead      = 1'b0;
        tick();
        bus.iMemWrite     = 1'b0;
    endtask

    // One load in the current cycle, checked through the scoreboard.
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus.iMemAddr = addr;
        bus.iMemRead = 1'b1;
        #1;
        check(tag_q.pop_front(), bus.oMemReadData, exp_q.pop_front());
        bus.iMemRead = 1'b0;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b1;
        bus.iMemAddr      = '0;
        bus.iMemWrite     = 1'b0;
        bus.iMemRead      = 1'b0;
        bus.iMemWriteData = '0;
        bus.iSwitch       = 8'h00;

        // Reset state, reads with reset held.
        tick();
        check("rst_irq",  32'(bus.oInterrupt), 32'd0);
        check("rst_led",  32'(bus.oLed),       32'd0);
        check("rst_digi", 32'(bus.oDigi),      32'd0);
        rd(A_TH,   32'd0, "rst_th");
        rd(A_TL,   32'd0, "rst_tl");
        rd(A_TCON, 32'd0, "rst_tcon");
        rd(A_LED,  32'd0, "rst_led_rd");
        tick();
        rd(A_SWITCH,  32'd0, "rst_switch");
        rd(A_DIGI,    32'd0, "rst_digi_rd");
        rd(A_SYSTICK, 32'd0, "rst_systick");
        reset = 1'b0;

        // Timer with TH = FFFF_FFFF - 3: interrupt every 4 enabled cycles.
        wr(A_TH, 32'hFFFF_FFFC);
        wr(A_TL, 32'hFFFF_FFFC);
        wr(A_TCON, 32'h3);
        rd(A_TL, 32'hFFFF_FFFC, "tl_after_enable");
        check("irq_e0", 32'(bus.oInterrupt), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("irq_e%0d", i), 32'(bus.oInterrupt), 32'd0);
        end
        tick();
        check("irq_rise_e4", 32'(bus.oInterrupt), 32'd1);
        rd(A_TL,   32'hFFFF_FFFC, "tl_reload");
        rd(A_TCON, 32'h7,         "tcon_status_set");

        // Clear status; next overflow lands on a TCON=3 write edge.
        wr(A_TCON, 32'h3);
        check("irq_cleared", 32'(bus.oInterrupt), 32'd0);
        rd(A_TL, 32'hFFFF_FFFD, "tl_after_clear");
        tick();
        tick();
        check("irq_e7", 32'(bus.oInterrupt), 32'd0);
        rd(A_TL, 32'hFFFF_FFFF, "tl_e7");
        wr(A_TCON, 32'h3);
        check("irq_collide", 32'(bus.oInterrupt), 32'd1);
        rd(A_TCON, 32'h7,         "tcon_collide");
        rd(A_TL,   32'hFFFF_FFFC, "tl_reload2");

        // CPU write to TL beats the increment.
        wr(A_TL, 32'h0000_1234);
        rd(A_TL, 32'h0000_1234, "tl_write_wins");
        tick();
        rd(A_TL, 32'h0000_1235, "tl_counts_on");

        // Disable: final enabled increment, then hold.
        wr(A_TCON, 32'h0);
        check("irq_off", 32'(bus.oInterrupt), 32'd0);
        rd(A_TL, 32'h0000_1236, "tl_last_inc");
        tick();
        tick();
        rd(A_TL, 32'h0000_1236, "tl_hold");

        // LED / DIGI, and writes to read-only or unmapped words are ignored.
        wr(A_LED,  32'hFFFF_FFA5);
        wr(A_DIGI, 32'h0000_0FFF);
        check("led_out",  32'(bus.oLed),  32'h0A5);
        check("digi_out", 32'(bus.oDigi), 32'hFFF);
        wr(A_SWITCH, 32'hFFFF_FFFF);
        wr(A_UNMAP,  32'h0000_0000);
        wr(A_SYSTICK, 32'h0);
        check("led_keep",  32'(bus.oLed),  32'h0A5);
        check("digi_keep", 32'(bus.oDigi), 32'hFFF);
        rd(A_LED,  32'h0000_00A5, "led_rd");
        rd(A_DIGI, 32'h0000_0FFF, "digi_rd");
        rd(A_TH,   32'hFFFF_FFFC, "th_keep");

        // Switch synchroniser: two edges of latency.
        bus.iSwitch = 8'h3C;
        tick();
        rd(A_SWITCH, 32'h0, "switch_1edge");
        tick();
        rd(A_SWITCH, 32'h3C, "switch_2edge");

        // Unmapped reads.
        rd(A_UNMAP,      32'h0, "unmapped_1c");
        rd(32'h5000_0000, 32'h0, "unmapped_far");

        // SYSTICK against the reference count, ten cycles apart.
        rd(A_SYSTICK, ref_ticks, "systick_a");
        for (int i = 0; i < 10; i++) tick();
        rd(A_SYSTICK, ref_ticks, "systick_b");
        bus.iMemAddr = A_SYSTICK;
        bus.iMemRead = 1'b0;
        #1;
        check("read_gate", bus.oMemReadData, 32'h0);

        // Asynchronous reset while counting with interrupt pending.
        wr(A_TCON, 32'h7);
        check("irq_sw_set", 32'(bus.oInterrupt), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_irq",  32'(bus.oInterrupt), 32'd0);
        check("arst_led",  32'(bus.oLed),       32'd0);
        check("arst_digi", 32'(bus.oDigi),      32'd0);
        rd(A_TL,      32'h0, "arst_tl");
        rd(A_SYSTICK, 32'h0, "arst_systick");
        tick();
        reset = 1'b0;
        tick();
        rd(A_TL, 32'h0, "tl_after_arst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
